// File: rtl/ysyx_22051086_pkg.sv
// Shared types for the memory arbiter: FSM states, transaction owner and the
// grant descriptor handed from the priority selector to the arbiter FSM.
package ysyx_22051086_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;

  localparam int CNT_W  = 3;
  localparam int MASK_W = 8;

  typedef struct packed {
    logic   valid;
    owner_t owner;
    logic   we;
  } grant_t;

endpackage

// File: rtl/ysyx_22051086_arb_prio.sv
// Combinational grant select: LS write, then LS read, then IF read, except
// that a starved IF request overrides everything.
module ysyx_22051086_arb_prio
  import ysyx_22051086_pkg::*;
(
  input  logic   i_if_req,
  input  logic   i_ls_rd_req,
  input  logic   i_ls_wr_req,
  input  logic   i_starve_hit,
  output grant_t o_grant
);

  always_comb begin
    o_grant = '{valid: 1'b0, owner: OWN_IF, we: 1'b0};
    if (i_if_req && i_starve_hit) begin
      o_grant = '{valid: 1'b1, owner: OWN_IF, we: 1'b0};
    end else if (i_ls_wr_req) begin
      // A simultaneous LS read stays pending behind the write.
      o_grant = '{valid: 1'b1, owner: OWN_LS, we: 1'b1};
    end else if (i_ls_rd_req) begin
      o_grant = '{valid: 1'b1, owner: OWN_LS, we: 1'b0};
    end else if (i_if_req) begin
      o_grant = '{valid: 1'b1, owner: OWN_IF, we: 1'b0};
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding memory arbiter between the IFU (reads) and LSU (reads and
// writes); IDLE -> ISSUE -> WAIT, with an anti-starvation counter for the IFU.
module mem_arbiter
  import ysyx_22051086_pkg::*;
#(
  parameter int AW         = 64,
  parameter int DW         = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  // Handshake: a requester raises *valid with stable fields and holds them
  // until its accept pulse (if_arready / ls_ready); response pulses are
  // one-cycle strobes with rdata passed straight through from memory.
  input  logic              if_arvalid,
  input  logic [AW-1:0]     if_araddr,
  output logic              if_arready,
  output logic              if_rvalid,
  output logic [DW-1:0]     if_rdata,
  input  logic              ls_arvalid,
  input  logic [AW-1:0]     ls_araddr,
  input  logic              ls_awvalid,
  input  logic [AW-1:0]     ls_awaddr,
  input  logic [DW-1:0]     ls_wdata,
  input  logic [MASK_W-1:0] ls_wmask,
  output logic              ls_ready,
  output logic              ls_rvalid,
  output logic [DW-1:0]     ls_rdata,
  output logic              ls_bvalid,
  output logic              mem_valid,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  output logic [MASK_W-1:0] mem_wmask,
  input  logic              mem_ready,
  input  logic              mem_resp,
  input  logic [DW-1:0]     mem_rdata,
  output state_t            dbg_state,
  output logic [CNT_W-1:0]  dbg_starve_cnt
);

  state_t              r_state;
  state_t              w_state_nxt;
  owner_t              r_owner;
  logic                r_we;
  logic [AW-1:0]       r_addr;
  logic [DW-1:0]       r_wdata;
  logic [MASK_W-1:0]   r_wmask;
  logic [CNT_W-1:0]    r_starve_cnt;
  logic [CNT_W-1:0]    w_starve_nxt;

  grant_t              w_grant;
  logic                w_starve_hit;
  logic                w_idle;
  logic                w_take;
  logic                w_resp;

  assign w_starve_hit = (r_starve_cnt == CNT_W'(STARVE_MAX));
  // Reset masks every strobe so an aborted transaction never pulses.
  assign w_idle       = (r_state == IDLE) && !rst;
  assign w_take       = w_idle && w_grant.valid;
  assign w_resp       = (r_state == WAIT) && mem_resp && !rst;

  ysyx_22051086_arb_prio u_arb_prio (
    .i_if_req     (if_arvalid),
    .i_ls_rd_req  (ls_arvalid),
    .i_ls_wr_req  (ls_awvalid),
    .i_starve_hit (w_starve_hit),
    .o_grant      (w_grant)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_take)    w_state_nxt = ISSUE;
      ISSUE:   if (mem_ready) w_state_nxt = WAIT;
      WAIT:    if (mem_resp)  w_state_nxt = IDLE;
      default:                w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_starve_nxt = r_starve_cnt;
    if (r_state == IDLE) begin
      if (!if_arvalid) begin
        w_starve_nxt = '0;
      end else if (w_take && (w_grant.owner == OWN_IF)) begin
        w_starve_nxt = '0;
      end else if (w_take && !w_starve_hit) begin
        w_starve_nxt = r_starve_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_owner      <= OWN_IF;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wmask      <= '0;
      r_starve_cnt <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_nxt;
      if (w_take) begin
        r_owner <= w_grant.owner;
        r_we    <= w_grant.we;
        if (w_grant.we) begin
          r_addr  <= ls_awaddr;
          r_wdata <= ls_wdata;
          r_wmask <= ls_wmask;
        end else begin
          r_addr  <= (w_grant.owner == OWN_LS) ? ls_araddr : if_araddr;
          r_wdata <= '0;
          r_wmask <= '0;
        end
      end
    end
  end

  assign if_arready     = w_take && (w_grant.owner == OWN_IF);
  assign ls_ready       = w_take && (w_grant.owner == OWN_LS);
  assign if_rvalid      = w_resp && (r_owner == OWN_IF) && !r_we;
  assign ls_rvalid      = w_resp && (r_owner == OWN_LS) && !r_we;
  assign ls_bvalid      = w_resp && (r_owner == OWN_LS) && r_we;
  assign if_rdata       = mem_rdata;
  assign ls_rdata       = mem_rdata;

  assign mem_valid      = (r_state == ISSUE) && !rst;
  assign mem_we         = mem_valid && r_we;
  assign mem_addr       = r_addr;
  assign mem_wdata      = r_wdata;
  assign mem_wmask      = r_wmask;

  assign dbg_state      = r_state;
  assign dbg_starve_cnt = r_starve_cnt;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic, checked by a
// transaction-level model feeding expected queues to an independent monitor.
`timescale 1ns/1ps
module tb_mem_arbiter;
  import ysyx_22051086_pkg::*;

  localparam int AW   = 64;
  localparam int DW   = 64;
  localparam int SMAX = 4;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [7:0]    wmask;
  } cmd_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic if_arvalid = 1'b0, ls_arvalid = 1'b0, ls_awvalid = 1'b0;
  logic [AW-1:0] if_araddr = '0, ls_araddr = '0, ls_awaddr = '0;
  logic [DW-1:0] ls_wdata = '0, mem_rdata = '0;
  logic [7:0] ls_wmask = '0;
  logic mem_ready = 1'b0, mem_resp = 1'b0;
  logic if_arready, if_rvalid, ls_ready, ls_rvalid, ls_bvalid;
  logic mem_valid, mem_we;
  logic [DW-1:0] if_rdata, ls_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [7:0] mem_wmask;
  state_t dbg_state;
  logic [CNT_W-1:0] dbg_starve_cnt;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .if_arvalid(if_arvalid), .if_araddr(if_araddr), .if_arready(if_arready),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_arvalid(ls_arvalid), .ls_araddr(ls_araddr), .ls_awvalid(ls_awvalid),
    .ls_awaddr(ls_awaddr), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
    .ls_ready(ls_ready), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .ls_bvalid(ls_bvalid),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_ready(mem_ready),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata),
    .dbg_state(dbg_state), .dbg_starve_cnt(dbg_starve_cnt)
  );

  int n_cmp = 0;
  int n_err = 0;
  int n_mv  = 0;

  // Strobe vector: {if_arready, ls_ready, if_rvalid, ls_rvalid, ls_bvalid, mem_valid, mem_we}
  logic [6:0]       strobe_q[$];
  logic [CNT_W-1:0] starve_q[$];
  cmd_t             cmd_q[$];
  logic [DW-1:0]    resp_q[$];

  logic if_acc = 1'b0;
  logic ls_acc = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: one transaction in flight; it is owned from its grant
  // until the memory answers after having accepted the command.
  int     m_phase = 0;  // 0 free, 1 command offered, 2 awaiting answer
  int     m_starve = 0;
  logic   m_we = 1'b0;
  logic   m_if = 1'b0;

  initial begin
    forever begin
      logic [6:0] s;
      cmd_t c;
      @(negedge clk);
      s = '0;
      starve_q.push_back(CNT_W'(m_starve));
      if (rst) begin
        m_phase = 0;
        m_starve = 0;
        cmd_q.delete();
      end else if (m_phase == 0) begin
        int pick;  // 0 none, 1 IF, 2 LS write, 3 LS read
        pick = 0;
        if (if_arvalid && m_starve == SMAX) pick = 1;
        else if (ls_awvalid)                pick = 2;
        else if (ls_arvalid)                pick = 3;
        else if (if_arvalid)                pick = 1;
        if (pick != 0) begin
          m_if = (pick == 1);
          m_we = (pick == 2);
          c = '{we: m_we, addr: (pick == 1) ? if_araddr : (pick == 2) ? ls_awaddr : ls_araddr,
                wdata: ls_wdata, wmask: ls_wmask};
          cmd_q.push_back(c);
          if (m_if) s[6] = 1'b1; else s[5] = 1'b1;
          m_phase = 1;
        end
        if (!if_arvalid || pick == 1) m_starve = 0;
        else if (pick != 0)           m_starve = (m_starve < SMAX) ? m_starve + 1 : SMAX;
      end else if (m_phase == 1) begin
        s[1] = 1'b1;
        s[0] = m_we;
        if (mem_ready) m_phase = 2;
      end else begin
        if (mem_resp) begin
          if (m_we)      s[2] = 1'b1;
          else if (m_if) s[4] = 1'b1;
          else           s[3] = 1'b1;
          resp_q.push_back(mem_rdata);
          m_phase = 0;
        end
      end
      strobe_q.push_back(s);
    end
  end

  // Monitor: compares what the DUT presents against the queued expectations.
  initial begin
    forever begin
      logic [6:0] act;
      @(negedge clk);
      #1;
      act = {if_arready, ls_ready, if_rvalid, ls_rvalid, ls_bvalid, mem_valid, mem_we};
      if (strobe_q.size() > 0) check("strobes", 64'(act), 64'(strobe_q.pop_front()));
      if (starve_q.size() > 0) check("starve_cnt", 64'(dbg_starve_cnt), 64'(starve_q.pop_front()));
      if_acc = if_arready;
      ls_acc = ls_ready;
      if (mem_valid) begin
        n_mv++;
        if (cmd_q.size() == 0) begin
          check("cmd_queue_nonempty", 64'(0), 64'(1));
        end else begin
          check("mem_we", 64'(mem_we), 64'(cmd_q[0].we));
          check("mem_addr", mem_addr, cmd_q[0].addr);
          if (cmd_q[0].we) begin
            check("mem_wdata", mem_wdata, cmd_q[0].wdata);
            check("mem_wmask", 64'(mem_wmask), 64'(cmd_q[0].wmask));
          end
          if (mem_ready) void'(cmd_q.pop_front());
        end
      end
      if (if_rvalid || ls_rvalid || ls_bvalid) begin
        if (resp_q.size() == 0) begin
          check("resp_queue_nonempty", 64'(0), 64'(1));
        end else begin
          logic [DW-1:0] e;
          e = resp_q.pop_front();
          if (if_rvalid) check("if_rdata", if_rdata, e);
          if (ls_rvalid) check("ls_rdata", ls_rdata, e);
        end
      end
    end
  end

  // Requesters drop a request once the cycle that accepted it has passed.
  task automatic step();
    @(posedge clk);
    #1;
    if (if_acc) if_arvalid = 1'b0;
    if (ls_acc) begin
      if (ls_awvalid) ls_awvalid = 1'b0;
      else            ls_arvalid = 1'b0;
    end
  endtask

  task automatic wait_idle(input string name);
    int c;
    c = 0;
    while ((m_phase != 0 || if_arvalid || ls_arvalid || ls_awvalid) && c < 300) begin
      step();
      c++;
    end
    if (c >= 300) check({name, "_timeout"}, 64'(0), 64'(1));
  endtask

  initial begin
    int ls_grants;
    int mv0;
    logic got_if;

    repeat (3) step();
    check("reset_state", 64'(dbg_state), 64'(IDLE));
    check("reset_addr", mem_addr, 64'(0));
    check("reset_wdata", mem_wdata, 64'(0));
    check("reset_wmask", 64'(mem_wmask), 64'(0));
    rst = 1'b0;

    // Lone IF read with an immediately responsive memory.
    mem_ready = 1'b1; mem_resp = 1'b1; mem_rdata = 64'h1234;
    if_arvalid = 1'b1; if_araddr = 64'h8000_0000;
    step();
    wait_idle("if_alone");

    // IF and LS reads together: LS first, then IF.
    mem_rdata = 64'h5555_aaaa;
    if_arvalid = 1'b1; if_araddr = 64'h8000_0040;
    ls_arvalid = 1'b1; ls_araddr = 64'h8000_2000;
    step();
    wait_idle("if_ls_race");

    // LS write with the memory stalling three cycles.
    mem_ready = 1'b0; mem_resp = 1'b0;
    ls_awvalid = 1'b1; ls_awaddr = 64'h8000_1000;
    ls_wdata = 64'hDEAD_BEEF; ls_wmask = 8'h0F;
    mv0 = n_mv;
    repeat (4) step();
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0; mem_resp = 1'b1;
    step();
    mem_resp = 1'b0;
    step();
    check("write_stall_valid_cycles", 64'(n_mv - mv0), 64'(4));
    check("write_stall_state", 64'(dbg_state), 64'(IDLE));

    // Continuous LS reads while IF waits.
    mem_ready = 1'b1; mem_resp = 1'b1;
    if_arvalid = 1'b1; if_araddr = 64'h8000_0100;
    ls_arvalid = 1'b1; ls_araddr = 64'h8000_3000;
    ls_grants = 0; got_if = 1'b0;
    for (int c = 0; c < 100 && !got_if; c++) begin
      step();
      if (ls_acc) begin
        ls_grants++;
        ls_arvalid = 1'b1;
        ls_araddr = 64'h8000_3000 + 64'(ls_grants * 8);
      end
      if (if_acc) got_if = 1'b1;
    end
    ls_arvalid = 1'b0;
    check("starve_if_granted", 64'(got_if), 64'(1));
    check("starve_ls_grants", 64'(ls_grants), 64'(SMAX));
    check("starve_cleared", 64'(dbg_starve_cnt), 64'(0));
    wait_idle("starve");

    // Spurious response while idle.
    mem_resp = 1'b1;
    repeat (3) step();
    check("spurious_state", 64'(dbg_state), 64'(IDLE));

    // Reset while waiting for a read response.
    mem_resp = 1'b0; mem_ready = 1'b1;
    ls_arvalid = 1'b1; ls_araddr = 64'h8000_4000;
    step();
    step();
    rst = 1'b1; mem_resp = 1'b1;
    step();
    rst = 1'b0;
    step();
    check("abort_state", 64'(dbg_state), 64'(IDLE));
    check("abort_addr", mem_addr, 64'(0));
    check("abort_mem_valid", 64'(mem_valid), 64'(0));
    mem_resp = 1'b0;

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      step();
      rst = ($urandom_range(0, 499) == 0);
      if (!if_arvalid && $urandom_range(0, 3) == 0) begin
        if_arvalid = 1'b1;
        if_araddr = {$urandom, $urandom};
      end
      if (!ls_arvalid && !ls_awvalid) begin
        int r;
        r = $urandom_range(0, 5);
        ls_arvalid = (r == 1 || r == 3);
        ls_awvalid = (r == 2 || r == 3);
        ls_araddr = {$urandom, $urandom};
        ls_awaddr = {$urandom, $urandom};
        ls_wdata = {$urandom, $urandom};
        ls_wmask = 8'($urandom);
      end
      mem_ready = ($urandom_range(0, 3) != 0);
      mem_resp = ($urandom_range(0, 2) != 0);
      mem_rdata = {$urandom, $urandom};
    end
    rst = 1'b0;
    mem_ready = 1'b1; mem_resp = 1'b1;
    wait_idle("drain");
    repeat (3) step();
    check("cmd_queue_drained", 64'(cmd_q.size()), 64'(0));
    check("resp_queue_drained", 64'(resp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter lines: AW, 64, address width; DW, 64, data width; STARVE_MAX, 4, consecutive LS grants allowed while IF waits.
REQ-002 The block SHALL use clk as its clock.
REQ-003 The block SHALL use rst as its reset: synchronous, active-high.
REQ-004 Port lines (name  direction  width  meaning):
  clk  in  1  clock
  rst  in  1  sync active-high reset
  if_arvalid  in  1  IFU read request
  if_araddr  in  AW  IFU read address
  if_arready  out  1  IFU request accepted (1-cycle pulse)
  if_rvalid  out  1  IFU read data valid (1-cycle pulse)
  if_rdata  out  DW  IFU read data
  ls_arvalid  in  1  LSU read request
  ls_araddr  in  AW  LSU read address
  ls_awvalid  in  1  LSU write request
  ls_awaddr  in  AW  LSU write address
  ls_wdata  in  DW  LSU write data
  ls_wmask  in  8  LSU byte-enable mask
  ls_ready  out  1  LSU request accepted (1-cycle pulse)
  ls_rvalid  out  1  LSU read data valid (1-cycle pulse)
  ls_rdata  out  DW  LSU read data
  ls_bvalid  out  1  LSU write complete (1-cycle pulse)
  mem_valid  out  1  memory command valid
  mem_we  out  1  1=write, 0=read
  mem_addr  out  AW  memory address
  mem_wdata  out  DW  memory write data
  mem_wmask  out  8  memory byte mask
  mem_ready  in  1  memory accepts command
  mem_resp  in  1  memory response (read data or write ack)
  mem_rdata  in  DW  memory read data

Function
REQ-005 States SHALL be IDLE, ISSUE, WAIT; only one transaction outstanding at any time.
REQ-006 Requesters SHALL hold valid/address/data stable until their accept pulse; arbiter SHALL sample them only in IDLE.
REQ-007 In IDLE, grant priority SHALL be: LS write, LS read, IF read; exception: if IF is pending and starve_cnt == STARVE_MAX, IF SHALL win.
REQ-008 On grant, the accept pulse (if_arready or ls_ready) SHALL assert combinationally in the same IDLE cycle; command fields and owner/type SHALL be latched; next state ISSUE.
REQ-009 In ISSUE, mem_valid=1 with latched fields; on mem_ready next state WAIT, else stay ISSUE with fields unchanged.
REQ-010 In WAIT, on mem_resp the owner's rvalid (read) or ls_bvalid (write) SHALL pulse in that same cycle, rdata = mem_rdata passthrough; next state IDLE.
REQ-011 Minimum latency: request seen in IDLE cycle N -> mem_valid cycle N+1 -> response pulse cycle N+2 (mem_ready and mem_resp each asserted at earliest opportunity).
REQ-012 starve_cnt (3 bits) SHALL increment on each LS grant while if_arvalid=1, saturate at STARVE_MAX, clear on any IF grant or when if_arvalid=0 in IDLE.
REQ-013 mem_resp outside WAIT, and mem_ready outside ISSUE, SHALL be ignored.
REQ-014 Outside ISSUE, mem_valid=0, mem_we=0; mem_addr/mem_wdata/mem_wmask hold last latched values.
REQ-015 if_rdata/ls_rdata SHALL equal mem_rdata at all times; only valid pulses qualify them.
REQ-016 Read requests with ls_arvalid and ls_awvalid both high SHALL serve the write first; the read stays pending.

Reset
REQ-017 On rst: state IDLE, starve_cnt 0, latched command regs 0, all valid/ready/pulse outputs 0.
REQ-018 rst during ISSUE or WAIT SHALL abort the transaction with no response pulse; any later mem_resp is ignored per REQ-013.

Structure
REQ-019 State encoding (IDLE/ISSUE/WAIT) and owner encoding (OWN_IF/OWN_LS) SHALL live in the shared package ysyx_22051086_pkg.
REQ-020 A sub-module ysyx_22051086_arb_prio SHALL implement the combinational grant select of REQ-007; FSM, latches and counter stay in mem_arbiter.

Verification
REQ-021 IF read 0x80000000 alone, mem_ready/mem_resp immediate, mem_rdata 0x1234 -> if_arready cycle 0, mem_valid cycle 1, if_rvalid with 0x1234 cycle 2.
REQ-022 IF and LS read asserted together -> LS granted first; IF granted on next IDLE; both rvalid pulses on correct port only.
REQ-023 LS write 0x80001000, wdata 0xDEADBEEF, wmask 0x0F, mem_ready delayed 3 cycles -> mem_valid held 4 cycles with stable fields, mem_we=1, ls_bvalid pulse on mem_resp.
REQ-024 LS reads continuously with IF pending, STARVE_MAX=4 -> exactly 4 LS grants, then IF granted, starve_cnt returns 0.
REQ-025 rst asserted in WAIT, then mem_resp -> no rvalid/bvalid pulse, state IDLE, all outputs at reset values.
REQ-026 Spurious mem_resp in IDLE -> no response pulse, state unchanged.
